// File: rtl/odd_result_pipe_pkg.sv
// Shared types and default constants for the odd-pipe result staging pipeline.
package odd_result_pipe_pkg;

    localparam int unsigned REG_ADDR_WD     = 7;
    localparam int unsigned REG_DATA_WD     = 128;
    localparam int unsigned STAT_WD         = 32;
    localparam int unsigned ODD_DEPTH       = 7;
    localparam int unsigned ODD_BR_LAT      = 1;
    localparam int unsigned ODD_PERM_LAT    = 3;
    localparam int unsigned ODD_LS_LAT      = 6;
    localparam int unsigned ODD_FLUSH_DEPTH = 1;

    typedef enum logic [1:0] {
        OU_NONE = 2'd0,
        OU_BR   = 2'd1,
        OU_PERM = 2'd2,
        OU_LS   = 2'd3
    } OddUnit_t;

    typedef struct packed {
        logic                   vld;
        logic                   wr_en;
        OddUnit_t               unit;
        logic [REG_ADDR_WD-1:0] addr;
        logic [REG_DATA_WD-1:0] data;
    } OddStage_t;

    // Stage index at which a unit's result is sampled; OU_NONE has none (0).
    function automatic int unsigned unit_lat(input OddUnit_t    unit,
                                             input int unsigned br_lat,
                                             input int unsigned perm_lat,
                                             input int unsigned ls_lat);
        case (unit)
            OU_BR:   return br_lat;
            OU_PERM: return perm_lat;
            OU_LS:   return ls_lat;
            default: return 0;
        endcase
    endfunction

    function automatic logic [REG_DATA_WD-1:0] unit_result(input OddUnit_t               unit,
                                                           input logic [REG_DATA_WD-1:0] br,
                                                           input logic [REG_DATA_WD-1:0] perm,
                                                           input logic [REG_DATA_WD-1:0] ls);
        case (unit)
            OU_BR:   return br;
            OU_PERM: return perm;
            OU_LS:   return ls;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/odd_result_pipe_if.sv
// Issue, result, forwarding and writeback signals of the odd-pipe result pipeline.
interface odd_result_pipe_if #(
    parameter int unsigned DEPTH = odd_result_pipe_pkg::ODD_DEPTH
) ();
    import odd_result_pipe_pkg::*;

    logic                   issue_vld;
    OddUnit_t               issue_unit;
    logic                   issue_wr_en;
    logic [REG_ADDR_WD-1:0] issue_rt_addr;
    logic [REG_DATA_WD-1:0] br_result;
    logic [REG_DATA_WD-1:0] perm_result;
    logic [REG_DATA_WD-1:0] ls_result;
    logic                   flush;

    logic                   fwd_vld  [2:DEPTH];
    logic                   fwd_rdy  [2:DEPTH];
    logic [REG_ADDR_WD-1:0] fwd_addr [2:DEPTH];
    logic [REG_DATA_WD-1:0] fwd_data [2:DEPTH];

    logic                   wb_en;
    logic [REG_ADDR_WD-1:0] wb_addr;
    logic [REG_DATA_WD-1:0] wb_data;

    modport master (
        output issue_vld, issue_unit, issue_wr_en, issue_rt_addr,
        output br_result, perm_result, ls_result, flush,
        input  fwd_vld, fwd_rdy, fwd_addr, fwd_data,
        input  wb_en, wb_addr, wb_data
    );

    modport slave (
        input  issue_vld, issue_unit, issue_wr_en, issue_rt_addr,
        input  br_result, perm_result, ls_result, flush,
        output fwd_vld, fwd_rdy, fwd_addr, fwd_data,
        output wb_en, wb_addr, wb_data
    );

endinterface

// File: rtl/odd_result_pipe_stage.sv
// One pipeline stage: takes the previous stage's entry, applies flush kill and
// captures the owning unit's result when the entry leaves its latency stage.
module odd_result_stage
    import odd_result_pipe_pkg::*;
#(
    parameter int unsigned STAGE_IDX   = 1,
    parameter int unsigned BR_LAT      = ODD_BR_LAT,
    parameter int unsigned PERM_LAT    = ODD_PERM_LAT,
    parameter int unsigned LS_LAT      = ODD_LS_LAT,
    parameter int unsigned FLUSH_DEPTH = ODD_FLUSH_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  OddStage_t              prev_stage,
    input  logic                   prev_rdy,
    input  logic                   flush,
    input  logic [REG_DATA_WD-1:0] br_result,
    input  logic [REG_DATA_WD-1:0] perm_result,
    input  logic [REG_DATA_WD-1:0] ls_result,
    output OddStage_t              stage,
    output logic                   rdy
);

    // Position of the incoming entry; 0 means it comes straight from issue.
    localparam int unsigned PREV_POS = STAGE_IDX - 1;
    localparam bit          KILL_EN  = (PREV_POS <= FLUSH_DEPTH);

    OddStage_t stage_d, stage_q;
    logic      rdy_d, rdy_q;
    logic      capture_c;

    always_comb begin
        stage_d   = '0;
        rdy_d     = 1'b0;
        capture_c = 1'b0;
        if (prev_stage.vld && !(KILL_EN && flush)) begin
            stage_d   = prev_stage;
            rdy_d     = prev_rdy;
            capture_c = (prev_stage.unit != OU_NONE) &&
                        (unit_lat(prev_stage.unit, BR_LAT, PERM_LAT, LS_LAT) == PREV_POS);
            if (capture_c) begin
                stage_d.data = unit_result(prev_stage.unit, br_result, perm_result, ls_result);
                rdy_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            rdy_q   <= rdy_d;
        end
    end

    assign stage = stage_q;
    assign rdy   = rdy_q;

endmodule

// File: rtl/odd_result_pipe.sv
// Odd-pipe result staging: DEPTH-stage tracker feeding forwarding and one RF write.
// Optional ODD_RESULT_STATS_EN adds stat_wb_cnt / stat_kill_cnt counters.
module odd_result_pipe
    import odd_result_pipe_pkg::*;
#(
    parameter int unsigned DEPTH       = ODD_DEPTH,
    parameter int unsigned BR_LAT      = ODD_BR_LAT,
    parameter int unsigned PERM_LAT    = ODD_PERM_LAT,
    parameter int unsigned LS_LAT      = ODD_LS_LAT,
    parameter int unsigned FLUSH_DEPTH = ODD_FLUSH_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    odd_result_pipe_if.slave   io
`ifdef ODD_RESULT_STATS_EN
    ,
    output logic [STAT_WD-1:0] stat_wb_cnt,
    output logic [STAT_WD-1:0] stat_kill_cnt
`endif
);

    OddStage_t issue_ent;
    OddStage_t stage_out [1:DEPTH];
    logic      rdy_out   [1:DEPTH];
    logic      wb_en_c;

    always_comb begin
        issue_ent       = '0;
        issue_ent.vld   = io.issue_vld;
        issue_ent.wr_en = io.issue_wr_en;
        issue_ent.unit  = io.issue_unit;
        issue_ent.addr  = io.issue_rt_addr;
    end

    for (genvar k = 1; k <= int'(DEPTH); k++) begin : g_stage
        OddStage_t prev;
        logic      prev_rdy;

        if (k == 1) begin : g_head
            assign prev     = issue_ent;
            assign prev_rdy = 1'b0;
        end else begin : g_body
            assign prev     = stage_out[k-1];
            assign prev_rdy = rdy_out[k-1];
        end

        odd_result_stage #(
            .STAGE_IDX   (k),
            .BR_LAT      (BR_LAT),
            .PERM_LAT    (PERM_LAT),
            .LS_LAT      (LS_LAT),
            .FLUSH_DEPTH (FLUSH_DEPTH)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .prev_stage  (prev),
            .prev_rdy    (prev_rdy),
            .flush       (io.flush),
            .br_result   (io.br_result),
            .perm_result (io.perm_result),
            .ls_result   (io.ls_result),
            .stage       (stage_out[k]),
            .rdy         (rdy_out[k])
        );
    end

    // Forwarding view; address/data are zeroed when the stage holds no writer.
    for (genvar k = 2; k <= int'(DEPTH); k++) begin : g_fwd
        logic vld_c;
        assign vld_c          = stage_out[k].vld & stage_out[k].wr_en;
        assign io.fwd_vld[k]  = vld_c;
        assign io.fwd_rdy[k]  = vld_c & rdy_out[k];
        assign io.fwd_addr[k] = vld_c ? stage_out[k].addr : '0;
        assign io.fwd_data[k] = vld_c ? stage_out[k].data : '0;
    end

    assign wb_en_c    = stage_out[DEPTH].vld & stage_out[DEPTH].wr_en & rdy_out[DEPTH];
    assign io.wb_en   = wb_en_c;
    assign io.wb_addr = wb_en_c ? stage_out[DEPTH].addr : '0;
    assign io.wb_data = wb_en_c ? stage_out[DEPTH].data : '0;

`ifdef ODD_RESULT_STATS_EN
    logic [STAT_WD-1:0] stat_wb_cnt_d, stat_wb_cnt_q;
    logic [STAT_WD-1:0] stat_kill_cnt_d, stat_kill_cnt_q;
    logic [STAT_WD-1:0] kill_inc_c;

    // Killed = valid entries in the flushable stages plus the dropped issue.
    always_comb begin
        kill_inc_c = '0;
        if (io.flush) begin
            kill_inc_c = STAT_WD'(io.issue_vld);
            for (int unsigned k = 1; k <= FLUSH_DEPTH; k++) begin
                kill_inc_c = kill_inc_c + STAT_WD'(stage_out[k].vld);
            end
        end
        stat_wb_cnt_d   = stat_wb_cnt_q + STAT_WD'(wb_en_c);
        stat_kill_cnt_d = stat_kill_cnt_q + kill_inc_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_wb_cnt_q   <= '0;
            stat_kill_cnt_q <= '0;
        end else begin
            stat_wb_cnt_q   <= stat_wb_cnt_d;
            stat_kill_cnt_q <= stat_kill_cnt_d;
        end
    end

    assign stat_wb_cnt   = stat_wb_cnt_q;
    assign stat_kill_cnt = stat_kill_cnt_q;
`endif

endmodule

// File: doc/odd_result_pipe.md
Name: odd_result_pipe

Overview:
- Result-staging pipeline downstream of the odd-pipe issue/execute logic (permute, load/store, branch units).
- Tracks every odd-pipe instruction from issue to writeback and captures each unit's result at that unit's latency.
- Presents per-stage destination address, data and ready flags to the forwarding network, and drives one register-file write per cycle from the last stage.

Parameters:
- REG_ADDR_WD, 7, register address width
- REG_DATA_WD, 128, register data width
- DEPTH, 7, number of stages; writeback occurs from stage DEPTH
- BR_LAT, 1, branch result latency in stages
- PERM_LAT, 3, permute result latency in stages
- LS_LAT, 6, load/store result latency in stages; every *_LAT must be in 1..DEPTH-1
- FLUSH_DEPTH, 1, stages 1..FLUSH_DEPTH are killed by flush

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- issue_vld  in  1  instruction enters stage 1 at this edge
- issue_unit  in  2  OddUnit_t: OU_NONE / OU_BR / OU_PERM / OU_LS
- issue_wr_en  in  1  instruction writes RT
- issue_rt_addr  in  REG_ADDR_WD  destination register
- br_result  in  REG_DATA_WD  branch-unit result, sampled per Behaviour
- perm_result  in  REG_DATA_WD  permute-unit result
- ls_result  in  REG_DATA_WD  load/store-unit result
- flush  in  1  kill younger entries (branch mispredict)
- fwd_vld  out  [2:DEPTH]x1  stage holds a writing instruction
- fwd_rdy  out  [2:DEPTH]x1  stage data valid for forwarding
- fwd_addr  out  [2:DEPTH]xREG_ADDR_WD  stage destination register
- fwd_data  out  [2:DEPTH]xREG_DATA_WD  stage result
- wb_en  out  1  register-file write enable
- wb_addr  out  REG_ADDR_WD  write address
- wb_data  out  REG_DATA_WD  write data

Behaviour:
- Each stage k holds the fields vld, wr_en, unit, addr, data and rdy. Every edge, stage k moves to stage k+1 with no stall. Stage DEPTH retires.
- Stage 1 loading:
  - Loads from the issue_* inputs when issue_vld=1 and flush=0.
  - Otherwise stage 1 vld becomes 0.
  - New entries have rdy=0 and data=0.
- Result capture:
  - When an entry sits in stage L (L = its unit's latency) with vld=1, it takes that unit's result bus at the edge while advancing to stage L+1, and sets rdy=1.
  - The data field holds its value in every later stage.
  - OU_NONE entries never become ready. They pass through and write nothing.
- fwd_vld[k] = vld & wr_en of stage k. fwd_rdy[k] = fwd_vld[k] & rdy. fwd_addr and fwd_data come straight from the stage registers.
- When fwd_vld[k]=0, fwd_addr[k] and fwd_data[k] are forced to 0.
- Writeback:
  - wb_en = vld & wr_en & rdy of stage DEPTH.
  - wb_addr and wb_data are driven from stage DEPTH when wb_en=1, and are 0 otherwise.
  - Latency: issue at edge N gives wb_en high in the cycle after edge N+DEPTH-1.
- Flush:
  - At an edge with flush=1, the current issue is dropped.
  - Entries currently in stages 1..FLUSH_DEPTH do not advance; their successor stages load vld=0.
  - Entries in later stages advance and capture normally.
- Same-cycle issue and flush: flush wins and nothing enters.
- Two entries reaching their capture stages in the same cycle is legal. Each entry selects its own unit bus.
- Reset (rst=0, any time, including mid-operation):
  - All vld, rdy, addr and data are cleared immediately.
  - All outputs are 0.
  - Operation resumes at the first edge after rst rises.

Optional Feature:
- Macro ODD_RESULT_STATS_EN.
- Defined:
  - Adds outputs stat_wb_cnt (32 bits) and stat_kill_cnt (32 bits).
  - stat_wb_cnt increments on each wb_en.
  - stat_kill_cnt increments by the number of valid entries killed by a flush, plus 1 for a dropped issue.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- defines_pkg holds:
  - OddUnit_t (2-bit enum).
  - OddStage_t, a packed struct of vld, wr_en, unit, addr and data.
  - Default latency constants ODD_BR_LAT, ODD_PERM_LAT and ODD_LS_LAT.
- One sub-module, odd_result_stage: a single stage register with capture mux, flush kill and async reset. It is instantiated DEPTH times via generate.

Test Plan:
- PERM issue at edge 0 with rt=5 and perm_result=0xA5.. held during stage 3 -> fwd_vld[2]=1, fwd_rdy[2]=0; fwd_rdy[4]=1 with data 0xA5..; wb_en=1, wb_addr=5, wb_data=0xA5.. after edge 6.
- LS issue (rt=9) followed next cycle by PERM issue (rt=10) -> both capture correctly; writebacks in consecutive cycles with addresses 9 then 10.
- Flush asserted together with issue_vld while a PERM entry sits in stage 1 and an LS entry in stage 3 -> the issue and the stage-1 entry vanish; LS writes back unaffected; stats (with macro) show stat_kill_cnt=2.
- issue_wr_en=0 and OU_NONE issues -> fwd_vld stays 0 and wb_en never rises; all fwd_addr/fwd_data read 0.
- Back-to-back issue every cycle for 20 cycles -> 20 writebacks in order, one per cycle, with no gaps.
- rst pulsed low for half a cycle with 4 entries in flight -> all outputs 0 asynchronously; no writeback from the killed entries after rst rises.
